// File: rtl/if_mem_ctrl_if.sv
// Fetch-side bus of the instruction memory controller: the IF-stage request
// and response signals together with the byte-wide RAM port.
interface if_mem_ctrl_if #(
    parameter int MEM_AW = 17
);
    logic              ce;
    logic [31:0]       raddr;
    logic              inv;
    logic              if_mem_ctrl_done;
    logic [31:0]       rdata;
    logic [MEM_AW-1:0] mem_a;
    logic [7:0]        mem_din;
    logic              mem_wr;

    // Environment side: IF stage plus the RAM that answers mem_a with mem_din.
    modport master (
        output ce, raddr, inv, mem_din,
        input  if_mem_ctrl_done, rdata, mem_a, mem_wr
    );

    // Controller side.
    modport slave (
        input  ce, raddr, inv, mem_din,
        output if_mem_ctrl_done, rdata, mem_a, mem_wr
    );
endinterface

// File: rtl/if_mem_ctrl.sv
// Instruction fetch memory controller: assembles a 32-bit little-endian
// instruction from four reads of a byte-wide RAM with one cycle of read
// latency, and holds the last fetched word so repeated fetches of the same
// address complete without touching the RAM.
module if_mem_ctrl #(
    parameter int MEM_AW = 17
) (
    input  logic          clk,
    input  logic          rst,
    if_mem_ctrl_if.slave  bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] S0   = 3'd1;
    localparam logic [2:0] S1   = 3'd2;
    localparam logic [2:0] S2   = 3'd3;
    localparam logic [2:0] S3   = 3'd4;
    localparam logic [2:0] S4   = 3'd5;

    logic [2:0]        r_state;
    logic [31:0]       r_base;
    logic [31:0]       r_word;
    logic              r_valid;
    logic [31:0]       r_done_addr;

    logic              w_done;
    logic              w_miss;
    logic              w_busy;
    logic              w_abort;
    logic              w_restart;
    logic              w_complete;
    logic [1:0]        w_offset;
    logic [MEM_AW-1:0] w_mem_a;

    // The held word answers the IF stage only while it is valid and matches.
    assign w_done     = r_valid && (bus.raddr == r_done_addr);
    assign w_miss     = bus.ce && !w_done;
    assign w_busy     = (r_state != IDLE);
    // Abort outranks restart, which outranks the normal step.
    assign w_abort    = w_busy && !bus.ce;
    assign w_restart  = w_busy && bus.ce && (bus.raddr != r_base);
    assign w_complete = (r_state == S4) && !w_abort && !w_restart;

    // Byte offset presented to the RAM in each read state.
    always_comb begin
        // NOTE: default assignment first so every path drives w_offset and no latch is inferred.
        w_offset = 2'd0;
        case (r_state)
            S1:      w_offset = 2'd1;
            S2:      w_offset = 2'd2;
            S3:      w_offset = 2'd3;
            default: w_offset = 2'd0;
        endcase
    end

    // Same-width add so the byte address wraps at the top of the RAM.
    assign w_mem_a = r_base[MEM_AW-1:0] + MEM_AW'(w_offset);

    assign bus.if_mem_ctrl_done = w_done;
    assign bus.rdata            = r_word;
    assign bus.mem_a            = w_mem_a;
    assign bus.mem_wr           = 1'b0;

    // Fetch sequencer: start on a miss, restart on a new address, abort when
    // the IF stage drops ce, otherwise step one state and capture bytes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state     <= IDLE;
            r_base      <= 32'd0;
            r_word      <= 32'd0;
            r_done_addr <= 32'd0;
        end else if (!w_busy) begin
            if (w_miss) begin
                r_base  <= bus.raddr;
                r_state <= S0;
            end
        end else if (w_abort) begin
            r_state <= IDLE;
        end else if (w_restart) begin
            r_base  <= bus.raddr;
            r_state <= S0;
        end else begin
            case (r_state)
                S0: r_state <= S1;
                S1: begin
                    r_word[7:0] <= bus.mem_din;
                    r_state     <= S2;
                end
                S2: begin
                    r_word[15:8] <= bus.mem_din;
                    r_state      <= S3;
                end
                S3: begin
                    r_word[23:16] <= bus.mem_din;
                    r_state       <= S4;
                end
                S4: begin
                    r_word[31:24] <= bus.mem_din;
                    r_done_addr   <= r_base;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Validity of the held word: invalidate beats a completing fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (bus.inv) begin
            r_valid <= 1'b0;
        end else if (w_complete) begin
            r_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_mem_ctrl.sv
// Self-checking bench for if_mem_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// cycle-level behavioural model of the fetch protocol.
module tb_if_mem_ctrl;

    localparam int MEM_AW   = 17;
    localparam int MEM_SIZE = 1 << MEM_AW;

    logic clk;
    logic rst;

    if_mem_ctrl_if #(.MEM_AW(MEM_AW)) bus ();

    if_mem_ctrl #(.MEM_AW(MEM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [7:0] ram [0:MEM_SIZE-1];

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    // Reference model: fetch progress as a cycle count, plus the held word.
    int          m_phase     = 0;   // 0 idle, 1..5 = cycle of the fetch (reading byte phase-1, phase 5 last capture)
    logic [31:0] m_base      = '0;
    logic [31:0] m_word      = '0;
    logic [31:0] m_done_addr = '0;
    logic        m_valid     = 1'b0;
    logic [MEM_AW-1:0] m_prev_a = '0;
    logic [7:0]  m_byte;
    logic        m_miss;
    logic        m_complete;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: byte for the address presented this cycle appears next cycle.
    always @(posedge clk) bus.mem_din <= ram[bus.mem_a];

    function automatic logic m_done();
        return m_valid && (bus.raddr == m_done_addr);
    endfunction

    function automatic logic [MEM_AW-1:0] m_mem_a();
        if (m_phase >= 1 && m_phase <= 4)
            return MEM_AW'(m_base + 32'(m_phase - 1));
        return m_base[MEM_AW-1:0];
    endfunction

    // Model update at each rising edge from the inputs held during the cycle.
    always @(posedge clk) begin
        m_byte     = ram[m_prev_a];
        m_prev_a   = m_mem_a();
        m_miss     = bus.ce && !m_done();
        m_complete = 1'b0;
        if (!rst) begin
            m_phase = 0; m_base = '0; m_word = '0; m_done_addr = '0; m_valid = 1'b0;
        end else begin
            if (m_phase == 0) begin
                if (m_miss) begin
                    m_base  = bus.raddr;
                    m_phase = 1;
                end
            end else if (!bus.ce) begin
                m_phase = 0;
            end else if (bus.raddr != m_base) begin
                m_base  = bus.raddr;
                m_phase = 1;
            end else begin
                if (m_phase >= 2) m_word[8*(m_phase-2) +: 8] = m_byte;
                if (m_phase == 5) begin
                    m_phase     = 0;
                    m_done_addr = m_base;
                    m_complete  = 1'b1;
                end else begin
                    m_phase = m_phase + 1;
                end
            end
            if (bus.inv) m_valid = 1'b0;
            else if (m_complete) m_valid = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_done",  32'(bus.if_mem_ctrl_done), 32'(m_done()));
            check("model_rdata", bus.rdata, m_word);
            check("model_mem_a", 32'(bus.mem_a), 32'(m_mem_a()));
            check("model_mem_wr", 32'(bus.mem_wr), 32'd0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pool [0:5];
    logic [MEM_AW-1:0] wrap_seq [0:3];

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) ram[i] = 8'($urandom);
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'hA0; ram[32'h103] = 8'h00;
        ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;
        ram[32'h300] = 8'hDE; ram[32'h301] = 8'hAD; ram[32'h302] = 8'hBE; ram[32'h303] = 8'hEF;
        ram[MEM_SIZE-2] = 8'hA1; ram[MEM_SIZE-1] = 8'hB2; ram[0] = 8'hC3; ram[1] = 8'hD4;

        rst = 1'b0; bus.ce = 1'b0; bus.inv = 1'b0; bus.raddr = 32'h0;
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        @(negedge clk);
        check("reset_done",  32'(bus.if_mem_ctrl_done), 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);
        check("reset_mem_a", 32'(bus.mem_a), 32'd0);

        // Basic fetch of 0x100.
        next_cycle(); rst = 1'b1; bus.ce = 1'b1; bus.raddr = 32'h100;
        @(negedge clk);
        check("basic_done_T0", 32'(bus.if_mem_ctrl_done), 32'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle(); @(negedge clk);
            check("basic_mem_a", 32'(bus.mem_a), 32'h100 + 32'(k));
        end
        next_cycle(); @(negedge clk);
        check("basic_done_T5", 32'(bus.if_mem_ctrl_done), 32'd0);
        next_cycle(); @(negedge clk);
        check("basic_done_T6", 32'(bus.if_mem_ctrl_done), 32'd1);
        check("basic_rdata",   bus.rdata, 32'h00A00513);

        // Hit hold.
        for (int k = 0; k < 10; k++) begin
            next_cycle(); @(negedge clk);
            check("hit_done",  32'(bus.if_mem_ctrl_done), 32'd1);
            check("hit_mem_a", 32'(bus.mem_a), 32'h100);
        end

        // Invalidate during a hit, then refetch of the same address.
        next_cycle(); bus.inv = 1'b1;
        next_cycle(); bus.inv = 1'b0;
        @(negedge clk);
        check("inv_done_fall", 32'(bus.if_mem_ctrl_done), 32'd0);
        for (int k = 0; k < 5; k++) begin
            next_cycle(); @(negedge clk);
            check("inv_refetch_busy", 32'(bus.if_mem_ctrl_done), 32'd0);
        end
        next_cycle(); @(negedge clk);
        check("inv_refetch_done",  32'(bus.if_mem_ctrl_done), 32'd1);
        check("inv_refetch_rdata", bus.rdata, 32'h00A00513);

        // Branch restart while reading byte 2 of 0x100.
        next_cycle(); bus.inv = 1'b1;
        next_cycle(); bus.inv = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle(); bus.raddr = 32'h200;
        next_cycle(); @(negedge clk);
        check("branch_mem_a", 32'(bus.mem_a), 32'h200);
        for (int k = 0; k < 4; k++) begin
            next_cycle(); @(negedge clk);
            check("branch_busy", 32'(bus.if_mem_ctrl_done), 32'd0);
        end
        next_cycle(); @(negedge clk);
        check("branch_done",  32'(bus.if_mem_ctrl_done), 32'd1);
        check("branch_rdata", bus.rdata, 32'h44332211);

        // Reset while reading byte 3 of 0x300, then a clean restart.
        next_cycle(); bus.raddr = 32'h300;
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle(); rst = 1'b0;
        next_cycle(); rst = 1'b1;
        @(negedge clk);
        check("rstmid_done",  32'(bus.if_mem_ctrl_done), 32'd0);
        check("rstmid_rdata", bus.rdata, 32'd0);
        check("rstmid_mem_a", 32'(bus.mem_a), 32'd0);
        for (int k = 0; k < 5; k++) begin
            next_cycle(); @(negedge clk);
            check("rstmid_busy", 32'(bus.if_mem_ctrl_done), 32'd0);
        end
        next_cycle(); @(negedge clk);
        check("rstmid_done_again", 32'(bus.if_mem_ctrl_done), 32'd1);
        check("rstmid_rdata_again", bus.rdata, 32'hEFBEADDE);

        // Address wrap at the top of the RAM.
        wrap_seq[0] = MEM_AW'(MEM_SIZE - 2);
        wrap_seq[1] = MEM_AW'(MEM_SIZE - 1);
        wrap_seq[2] = '0;
        wrap_seq[3] = MEM_AW'(1);
        next_cycle(); bus.raddr = 32'(MEM_SIZE - 2);
        for (int k = 0; k < 4; k++) begin
            next_cycle(); @(negedge clk);
            check("wrap_mem_a", 32'(bus.mem_a), 32'(wrap_seq[k]));
        end
        next_cycle();
        next_cycle(); @(negedge clk);
        check("wrap_done",  32'(bus.if_mem_ctrl_done), 32'd1);
        check("wrap_rdata", bus.rdata, 32'hD4C3B2A1);

        // Randomized traffic: address changes, ce drops, invalidates, resets.
        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200;
        pool[3] = 32'h300; pool[4] = 32'(MEM_SIZE - 2); pool[5] = 32'(MEM_SIZE - 3);
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if ($urandom_range(0, 99) < 8) bus.raddr = pool[$urandom_range(0, 5)];
            bus.ce  = ($urandom_range(0, 9) != 0);
            bus.inv = ($urandom_range(0, 29) == 0);
            rst     = ($urandom_range(0, 199) != 0);
        end
        next_cycle(); rst = 1'b1; bus.inv = 1'b0; bus.ce = 1'b1;
        repeat (10) next_cycle();
        @(negedge clk);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
